// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller
package pipe_pkg;
    typedef enum logic {RUN, MC_WAIT} state_t;
    localparam logic [4:0] REG_X0 = 5'd0;
    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctl_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID sources and the EX load destination
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       id_rs1_re,
    input  logic       id_rs2_re,
    input  logic       ex_rd_we,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_is_load,
    output logic       load_use
);
    assign load_use = ex_is_load && ex_rd_we && ex_rd_addr != REG_X0 &&
                      ((id_rs1_re && id_rs1_addr == ex_rd_addr) ||
                       (id_rs2_re && id_rs2_addr == ex_rd_addr));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic        id_rs1_re,
    input  logic        id_rs2_re,
    input  logic        ex_rd_we,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_is_load,
    input  logic        ex_branch_taken,
    input  logic        ex_mc_start,
    input  logic        mc_done,
    input  logic        mem_busy,
    output logic        stall_pc,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        stall_ex_mem,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        flush_ex_mem,
    output logic        mc_timeout,
    output logic [31:0] stall_cycles
);
    localparam int CW = $clog2(MC_TIMEOUT + 1);
    state_t          state_q, state_d;
    logic            done_seen_q, done_seen_d;
    logic [CW-1:0]   mc_cnt_q, mc_cnt_d;
    logic            mc_timeout_q, mc_timeout_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;
    logic            load_use, done, mc_to, pc_stall;
    pipe_ctl_t       if_id, id_ex, ex_mem;

    hazard_detect u_hazard_detect (
        .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr),
        .id_rs1_re  (id_rs1_re),
        .id_rs2_re  (id_rs2_re),
        .ex_rd_we   (ex_rd_we),
        .ex_rd_addr (ex_rd_addr),
        .ex_is_load (ex_is_load),
        .load_use   (load_use)
    );

    always_comb begin
        done         = mc_done || done_seen_q;
        mc_to        = state_q == MC_WAIT && !done && mc_cnt_q == CW'(MC_TIMEOUT - 1);
        state_d      = state_q;
        done_seen_d  = done_seen_q;
        mc_cnt_d     = mc_cnt_q;
        mc_timeout_d = 1'b0;
        pc_stall     = 1'b0;
        if_id        = '0;
        id_ex        = '0;
        ex_mem       = '0;
        if (rst) begin
        end else if (mem_busy) begin
            pc_stall     = 1'b1;
            if_id.stall  = 1'b1;
            id_ex.stall  = 1'b1;
            ex_mem.stall = 1'b1;
            done_seen_d  = done_seen_q || (state_q == MC_WAIT && mc_done);
        end else if (state_q == RUN && ex_mc_start) begin
            pc_stall     = 1'b1;
            if_id.stall  = 1'b1;
            id_ex.stall  = 1'b1;
            ex_mem.flush = 1'b1;
            state_d      = MC_WAIT;
            mc_cnt_d     = '0;
            done_seen_d  = 1'b0;
        end else if (state_q == MC_WAIT && !done && !mc_to) begin
            pc_stall     = 1'b1;
            if_id.stall  = 1'b1;
            id_ex.stall  = 1'b1;
            ex_mem.flush = 1'b1;
            mc_cnt_d     = mc_cnt_q + CW'(1);
        end else if (state_q == MC_WAIT) begin
            state_d      = RUN;
            done_seen_d  = 1'b0;
            mc_timeout_d = mc_to;
        end else if (ex_branch_taken) begin
            if_id.flush  = 1'b1;
            id_ex.flush  = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id.stall  = 1'b1;
            id_ex.flush  = 1'b1;
        end
        stall_cycles_d = stall_cycles_q + 32'(pc_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            done_seen_q    <= 1'b0;
            mc_cnt_q       <= '0;
            mc_timeout_q   <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            done_seen_q    <= done_seen_d;
            mc_cnt_q       <= mc_cnt_d;
            mc_timeout_q   <= mc_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_pc     = pc_stall;
    assign stall_if_id  = if_id.stall;
    assign stall_id_ex  = id_ex.stall;
    assign stall_ex_mem = ex_mem.stall;
    assign flush_if_id  = if_id.flush;
    assign flush_id_ex  = id_ex.flush;
    assign flush_ex_mem = ex_mem.flush;
    assign mc_timeout   = mc_timeout_q;
    assign stall_cycles = stall_cycles_q;
endmodule
